// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the TCM SoC slice.
// Holds the major opcodes, load/store size codes (funct3), the ALU operation
// enum and its funct3 decoder, the performance-counter slot numbers and the
// branch-predictor reset value.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    // Counter slots; slot TC_R lands in the top 32 bits of dbg_type_cnt_o.
    localparam int unsigned TC_J   = 0;
    localparam int unsigned TC_U   = 1;
    localparam int unsigned TC_B   = 2;
    localparam int unsigned TC_S   = 3;
    localparam int unsigned TC_I   = 4;
    localparam int unsigned TC_R   = 5;
    localparam int unsigned TC_NUM = 6;

    localparam logic [1:0] BHT_INIT = 2'b01;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_t;

    // SUB exists only for register-register ops; funct7[5] selects SRA for both.
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic f7_5,
                                           input logic is_op);
        case (f3)
            3'b000:  return (is_op && f7_5) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return f7_5 ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_bimodal_bht.sv
// Bimodal branch history table of 2-bit saturating counters.
// Ports: i_clk/i_rst (async active-high, entries reset to BHT_INIT),
//        i_idx  entry index, o_pred counter MSB before any update,
//        i_upd  update strobe, i_taken actual outcome (+1 taken / -1 not taken).
module riscv_bimodal_bht
    import riscv_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [$clog2(ENTRIES)-1:0] i_idx,
    input  logic                       i_upd,
    input  logic                       i_taken,
    output logic                       o_pred
);

    logic [1:0] r_ctr [ENTRIES];

    assign o_pred = r_ctr[i_idx][1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) r_ctr[i] <= BHT_INIT;
        end else if (i_upd) begin
            if (i_taken && r_ctr[i_idx] != 2'b11)
                r_ctr[i_idx] <= r_ctr[i_idx] + 2'd1;
            else if (!i_taken && r_ctr[i_idx] != 2'b00)
                r_ctr[i_idx] <= r_ctr[i_idx] - 2'd1;
        end
    end

endmodule

// File: rtl/riscv_tcm_soc.sv
// Minimal RV32I SoC: single-cycle core with one unified TCM for fetch and data.
// Ports: clk_i, rst_i (async global reset), rst_cpu_i (sync core start pulse),
//        tb_inst_* preload write port, dbg_* retire trace, per-format
//        retire counters {R,I,S,B,U,J} and branch-predictor hit counter.
module riscv_tcm_soc
    import riscv_pkg::*;
#(
    parameter int unsigned CORE_ID            = 0,
    parameter logic [31:0] MEM_CACHE_ADDR_MIN = 32'h0,
    parameter logic [31:0] MEM_CACHE_ADDR_MAX = 32'hffffffff,
    parameter int unsigned TCM_WORDS          = 4096,
    parameter int unsigned BHT_ENTRIES        = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rst_cpu_i,
    input  logic [3:0]   tb_inst_we_i,
    input  logic [31:0]  tb_inst_addr_i,
    input  logic [31:0]  tb_inst_data_i,
    output logic [31:0]  dbg_pc_o,
    output logic         dbg_retire_o,
    output logic         dbg_cond_branch_o,
    output logic         dbg_branch_taken_o,
    output logic         dbg_branch_pred_o,
    output logic [191:0] dbg_type_cnt_o,
    output logic [31:0]  dbg_pred_hit_cnt_o
);

    localparam int unsigned AW = $clog2(TCM_WORDS);
    localparam int unsigned BW = $clog2(BHT_ENTRIES);

    logic [31:0] r_mem  [TCM_WORDS];
    logic [31:0] r_regs [32];
    logic [31:0] r_pc, r_hit_cnt;
    logic [31:0] r_cnt  [TC_NUM];
    logic        r_run, r_halted;

    logic [31:0] w_inst, w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1v, w_rs2v, w_alu_b, w_alu_y, w_pc4, w_wb_data, w_next_pc;
    logic [31:0] w_daddr, w_dword, w_lane, w_load_data, w_st_data;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [3:0]  w_st_be;
    logic [5:0]  w_type_hot;
    logic [AW-1:0] w_didx, w_tb_idx;
    alu_op_t     w_alu_op;
    logic        w_retire, w_cond, w_pred, w_wb_en, w_is_branch, w_halt;
    logic        w_dhit, w_st_en, w_pre_hit, w_unused;

    assign w_unused = ^{32'(CORE_ID), tb_inst_addr_i[1:0], tb_inst_addr_i[31:AW+2]};

    // X on rst_cpu_i never reaches r_run: the if() below treats it as false.
    assign w_retire = r_run & ~rst_cpu_i & ~r_halted;

    // Fetch and decode
    assign w_inst   = r_mem[r_pc[AW+1:2]];
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_funct3 = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_imm_i  = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u  = {w_inst[31:12], 12'b0};
    assign w_imm_j  = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_rs1v   = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1];
    assign w_rs2v   = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2];
    assign w_pc4    = r_pc + 32'd4;

    // ALU
    assign w_alu_op = alu_decode(w_funct3, w_inst[30], w_opcode == OPC_OP);
    assign w_alu_b  = (w_opcode == OPC_OP) ? w_rs2v : w_imm_i;

    always_comb begin
        case (w_alu_op)
            ALU_ADD:  w_alu_y = w_rs1v + w_alu_b;
            ALU_SUB:  w_alu_y = w_rs1v - w_alu_b;
            ALU_SLL:  w_alu_y = w_rs1v << w_alu_b[4:0];
            ALU_SLT:  w_alu_y = {31'b0, $signed(w_rs1v) < $signed(w_alu_b)};
            ALU_SLTU: w_alu_y = {31'b0, w_rs1v < w_alu_b};
            ALU_XOR:  w_alu_y = w_rs1v ^ w_alu_b;
            ALU_SRL:  w_alu_y = w_rs1v >> w_alu_b[4:0];
            ALU_SRA:  w_alu_y = $signed(w_rs1v) >>> w_alu_b[4:0];
            ALU_OR:   w_alu_y = w_rs1v | w_alu_b;
            default:  w_alu_y = w_rs1v & w_alu_b;
        endcase
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_cond = (w_rs1v == w_rs2v);
            3'b001:  w_cond = (w_rs1v != w_rs2v);
            3'b100:  w_cond = ($signed(w_rs1v) <  $signed(w_rs2v));
            3'b101:  w_cond = ($signed(w_rs1v) >= $signed(w_rs2v));
            3'b110:  w_cond = (w_rs1v <  w_rs2v);
            3'b111:  w_cond = (w_rs1v >= w_rs2v);
            default: w_cond = 1'b0;
        endcase
    end

    // Data port: window check is a single unsigned compare after offsetting by MIN.
    assign w_daddr = w_rs1v + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_dhit  = ((w_daddr - MEM_CACHE_ADDR_MIN) <= (MEM_CACHE_ADDR_MAX - MEM_CACHE_ADDR_MIN))
                  && (w_daddr[31:2] < 30'(TCM_WORDS));
    assign w_didx  = w_daddr[AW+1:2];
    assign w_dword = w_dhit ? r_mem[w_didx] : '0;
    assign w_lane  = w_dword >> {w_daddr[1:0], 3'b000};

    always_comb begin
        case (w_funct3)
            LS_B:    w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
            LS_H:    w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
            LS_BU:   w_load_data = {24'b0, w_lane[7:0]};
            LS_HU:   w_load_data = {16'b0, w_lane[15:0]};
            default: w_load_data = w_dword;
        endcase
    end

    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                w_st_be   = 4'b0001 << w_daddr[1:0];
                w_st_data = w_rs2v << {w_daddr[1:0], 3'b000};
            end
            2'b01: begin
                w_st_be   = 4'b0011 << w_daddr[1:0];
                w_st_data = w_rs2v << {w_daddr[1:0], 3'b000};
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = w_rs2v;
            end
        endcase
    end

    // Control / writeback selection
    always_comb begin
        w_wb_en     = 1'b0;
        w_wb_data   = w_alu_y;
        w_next_pc   = w_pc4;
        w_is_branch = 1'b0;
        w_halt      = 1'b0;
        w_type_hot  = '0;
        case (w_opcode)
            OPC_LUI:    begin w_wb_en = 1'b1; w_wb_data = w_imm_u; w_type_hot[TC_U] = 1'b1; end
            OPC_AUIPC:  begin w_wb_en = 1'b1; w_wb_data = r_pc + w_imm_u; w_type_hot[TC_U] = 1'b1; end
            OPC_JAL: begin
                w_wb_en = 1'b1; w_wb_data = w_pc4; w_next_pc = r_pc + w_imm_j;
                w_type_hot[TC_J] = 1'b1;
            end
            OPC_JALR: begin
                w_wb_en = 1'b1; w_wb_data = w_pc4;
                w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
                w_type_hot[TC_I] = 1'b1;
            end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                if (w_cond) w_next_pc = r_pc + w_imm_b;
                w_type_hot[TC_B] = 1'b1;
            end
            OPC_LOAD:   begin w_wb_en = 1'b1; w_wb_data = w_load_data; w_type_hot[TC_I] = 1'b1; end
            OPC_STORE:  w_type_hot[TC_S] = 1'b1;
            OPC_OPIMM:  begin w_wb_en = 1'b1; w_type_hot[TC_I] = 1'b1; end
            OPC_OP:     begin w_wb_en = 1'b1; w_type_hot[TC_R] = 1'b1; end
            OPC_MISC:   w_type_hot[TC_I] = 1'b1;
            OPC_SYSTEM: begin w_halt = 1'b1; w_next_pc = r_pc; w_type_hot[TC_I] = 1'b1; end
            default:    ;
        endcase
    end

    // TCM writes: the preload port wins over a core store to the same word.
    assign w_tb_idx  = tb_inst_addr_i[AW+1:2];
    assign w_pre_hit = (|tb_inst_we_i) && (w_tb_idx == w_didx);
    assign w_st_en   = w_retire && (w_opcode == OPC_STORE) && w_dhit && !w_pre_hit;

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_st_en && w_st_be[b])
                r_mem[w_didx][8*b +: 8] <= w_st_data[8*b +: 8];
            if (tb_inst_we_i[b])
                r_mem[w_tb_idx][8*b +: 8] <= tb_inst_data_i[8*b +: 8];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_retire && w_wb_en && w_rd != 5'd0)
            r_regs[w_rd] <= w_wb_data;
    end

    riscv_bimodal_bht #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_idx   (r_pc[BW+1:2]),
        .i_upd   (w_retire && w_is_branch),
        .i_taken (w_cond),
        .o_pred  (w_pred)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc      <= '0;
            r_run     <= 1'b0;
            r_halted  <= 1'b0;
            r_hit_cnt <= '0;
            for (int unsigned i = 0; i < TC_NUM; i++) r_cnt[i] <= '0;
        end else if (rst_cpu_i) begin
            r_pc      <= '0;
            r_run     <= 1'b1;
            r_halted  <= 1'b0;
            r_hit_cnt <= '0;
            for (int unsigned i = 0; i < TC_NUM; i++) r_cnt[i] <= '0;
        end else if (w_retire) begin
            r_pc <= w_next_pc;
            if (w_halt) r_halted <= 1'b1;
            if (w_is_branch && (w_pred == w_cond)) r_hit_cnt <= r_hit_cnt + 32'd1;
            for (int unsigned i = 0; i < TC_NUM; i++)
                if (w_type_hot[i]) r_cnt[i] <= r_cnt[i] + 32'd1;
        end
    end

    assign dbg_retire_o       = w_retire;
    assign dbg_pc_o           = w_retire ? r_pc : '0;
    assign dbg_cond_branch_o  = w_retire & w_is_branch;
    assign dbg_branch_taken_o = w_retire & w_is_branch & w_cond;
    assign dbg_branch_pred_o  = w_retire & w_is_branch & w_pred;
    assign dbg_type_cnt_o     = {r_cnt[TC_R], r_cnt[TC_I], r_cnt[TC_S],
                                 r_cnt[TC_B], r_cnt[TC_U], r_cnt[TC_J]};
    assign dbg_pred_hit_cnt_o = r_hit_cnt;

endmodule

// File: tb/tb_riscv_tcm_soc.sv
// Self-checking bench for riscv_tcm_soc: expected retire records are queued
// before each program starts and compared as the core retires them.
module tb_riscv_tcm_soc;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         rst_cpu_i = 1'b0;
    logic [3:0]   tb_inst_we_i = '0;
    logic [31:0]  tb_inst_addr_i = '0;
    logic [31:0]  tb_inst_data_i = '0;
    logic [31:0]  dbg_pc_o;
    logic         dbg_retire_o, dbg_cond_branch_o, dbg_branch_taken_o, dbg_branch_pred_o;
    logic [191:0] dbg_type_cnt_o;
    logic [31:0]  dbg_pred_hit_cnt_o;

    riscv_tcm_soc #(
        .MEM_CACHE_ADDR_MIN (32'h0000_0000),
        .MEM_CACHE_ADDR_MAX (32'h0000_0fff)
    ) u_dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .rst_cpu_i          (rst_cpu_i),
        .tb_inst_we_i       (tb_inst_we_i),
        .tb_inst_addr_i     (tb_inst_addr_i),
        .tb_inst_data_i     (tb_inst_data_i),
        .dbg_pc_o           (dbg_pc_o),
        .dbg_retire_o       (dbg_retire_o),
        .dbg_cond_branch_o  (dbg_cond_branch_o),
        .dbg_branch_taken_o (dbg_branch_taken_o),
        .dbg_branch_pred_o  (dbg_branch_pred_o),
        .dbg_type_cnt_o     (dbg_type_cnt_o),
        .dbg_pred_hit_cnt_o (dbg_pred_hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] pc;
        logic        cond;
        logic        taken;
        logic        pred;
    } ret_t;

    ret_t        exp_q[$];
    logic [31:0] prog[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Tiny assembler helpers
    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, input int rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    task automatic poke(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] we);
        @(posedge clk_i); #1;
        tb_inst_we_i = we; tb_inst_addr_i = addr; tb_inst_data_i = data;
        @(posedge clk_i); #1;
        tb_inst_we_i = '0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) poke(32'(i * 4), prog[i], 4'hf);
    endtask

    task automatic push(input logic [31:0] pc, input logic c, input logic t, input logic p);
        ret_t r;
        r.pc = pc; r.cond = c; r.taken = t; r.pred = p;
        exp_q.push_back(r);
    endtask

    task automatic pulse_start();
        @(posedge clk_i); #1 rst_cpu_i = 1'b1;
        @(posedge clk_i); #1 rst_cpu_i = 1'b0;
    endtask

    task automatic hard_reset();
        @(posedge clk_i); #1 rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int maxc);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            @(negedge clk_i); #1;
            c++;
        end
        check_eq({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_cnts(input string tag, input int r, input int i, input int s,
                              input int b, input int u, input int j, input int hit);
        int e[6];
        e = '{r, i, s, b, u, j};
        for (int k = 0; k < 6; k++)
            check_eq($sformatf("%s_cnt%0d", tag, k), 64'(dbg_type_cnt_o[191-32*k -: 32]), 64'(e[k]));
        check_eq({tag, "_hit"}, 64'(dbg_pred_hit_cnt_o), 64'(hit));
    endtask

    // Retire monitor / scoreboard
    always @(negedge clk_i) begin
        if (dbg_retire_o) begin
            if (exp_q.size() == 0) begin
                check_eq("retire_unexpected", 64'(dbg_retire_o), 64'd0);
            end else begin
                ret_t r;
                r = exp_q.pop_front();
                check_eq("ret_pc",    64'(dbg_pc_o),           64'(r.pc));
                check_eq("ret_cond",  64'(dbg_cond_branch_o),  64'(r.cond));
                check_eq("ret_taken", 64'(dbg_branch_taken_o), 64'(r.taken));
                check_eq("ret_pred",  64'(dbg_branch_pred_o),  64'(r.pred));
            end
        end else begin
            check_eq("idle_outs", 64'({dbg_pc_o, dbg_cond_branch_o, dbg_branch_taken_o,
                                       dbg_branch_pred_o}), 64'd0);
        end
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        check_cnts("rst", 0, 0, 0, 0, 0, 0, 0);
        check_eq("rst_pc", 64'(u_dut.r_pc), 64'd0);
        check_eq("rst_bht", 64'(u_dut.u_bht.r_ctr[2]), 64'd1);

        // Preload byte enables
        poke(32'h10, 32'hdeadbeef, 4'hf);
        poke(32'h10, 32'h00000055, 4'h1);
        check_eq("preload_word", 64'(u_dut.r_mem[4]), 64'hdeadbe55);

        // ALU / memory / type counters, with idle period before start
        prog = '{enc_i(5, 0, 0, 1, 7'h13), enc_i(7, 0, 0, 2, 7'h13), enc_r(0, 2, 1, 0, 3),
                 enc_s(32'h100, 3, 0, 2), enc_i(32'h100, 0, 2, 4, 7'h03), enc_u(1, 5, 7'h37),
                 enc_j(4, 0), EBREAK};
        load_prog();
        @(posedge clk_i); #1 rst_cpu_i = 1'bx;
        repeat (10) begin @(negedge clk_i); check_eq("idle_x", 64'(dbg_retire_o), 64'd0); end
        @(posedge clk_i); #1 rst_cpu_i = 1'b0;
        repeat (10) begin @(negedge clk_i); check_eq("idle_0", 64'(dbg_retire_o), 64'd0); end
        for (int i = 0; i < 8; i++) push(32'(i * 4), 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_drain("alu", 40);
        check_eq("alu_x4", 64'(u_dut.r_regs[4]), 64'd12);
        check_eq("alu_x5", 64'(u_dut.r_regs[5]), 64'h1000);
        check_eq("alu_mem100", 64'(u_dut.r_mem[64]), 64'd12);
        check_cnts("alu", 1, 4, 1, 0, 1, 1, 0);

        // Branch predictor on a three-iteration loop
        hard_reset();
        prog = '{enc_i(3, 0, 0, 1, 7'h13), enc_i(-1, 1, 0, 1, 7'h13), enc_b(-4, 0, 1, 1), EBREAK};
        load_prog();
        push(0, 0, 0, 0);
        push(4, 0, 0, 0); push(8, 1, 1, 0);
        push(4, 0, 0, 0); push(8, 1, 1, 1);
        push(4, 0, 0, 0); push(8, 1, 0, 1);
        push(12, 0, 0, 0);
        pulse_start();
        wait_drain("bp", 40);
        check_cnts("bp", 0, 5, 0, 3, 0, 0, 1);
        check_eq("bp_bht", 64'(u_dut.u_bht.r_ctr[2]), 64'h2);

        // Data window boundary and sub-word loads/stores
        hard_reset();
        poke(32'h1000, 32'ha5a5a5a5, 4'hf);
        poke(32'h200, 32'h11223344, 4'hf);
        prog = '{enc_u(1, 1, 7'h37), enc_i(32'h7b, 0, 0, 2, 7'h13), enc_s(0, 2, 1, 2),
                 enc_i(0, 1, 2, 3, 7'h03), enc_i(32'h80, 0, 0, 4, 7'h13), enc_s(32'h203, 4, 0, 0),
                 enc_i(32'h203, 0, 0, 5, 7'h03), enc_i(32'h203, 0, 4, 6, 7'h03),
                 enc_i(32'h202, 0, 1, 7, 7'h03), EBREAK};
        load_prog();
        for (int i = 0; i < 10; i++) push(32'(i * 4), 1'b0, 1'b0, 1'b0);
        pulse_start();
        wait_drain("mem", 40);
        check_eq("mem_oob_load", 64'(u_dut.r_regs[3]), 64'd0);
        check_eq("mem_oob_store", 64'(u_dut.r_mem[1024]), 64'ha5a5a5a5);
        check_eq("mem_sb_word", 64'(u_dut.r_mem[128]), 64'h80223344);
        check_eq("mem_lb", 64'(u_dut.r_regs[5]), 64'hffffff80);
        check_eq("mem_lbu", 64'(u_dut.r_regs[6]), 64'h00000080);
        check_eq("mem_lh", 64'(u_dut.r_regs[7]), 64'hffff8022);
        check_cnts("mem", 0, 7, 2, 0, 1, 0, 0);

        // Asynchronous reset in the middle of an endless loop
        hard_reset();
        prog = '{enc_i(0, 0, 0, 1, 7'h13), enc_i(1, 1, 0, 1, 7'h13), enc_j(-4, 0)};
        load_prog();
        push(0, 0, 0, 0); push(4, 0, 0, 0); push(8, 0, 0, 0); push(4, 0, 0, 0);
        pulse_start();
        repeat (4) @(negedge clk_i);
        #1;
        check_cnts("loop", 0, 2, 0, 0, 0, 1, 0);
        #1 rst_i = 1'b1;
        #1;
        check_cnts("async", 0, 0, 0, 0, 0, 0, 0);
        check_eq("async_pc", 64'(u_dut.r_pc), 64'd0);
        check_eq("async_retire", 64'(dbg_retire_o), 64'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        repeat (10) begin @(negedge clk_i); check_eq("post_rst_idle", 64'(dbg_retire_o), 64'd0); end
        push(0, 0, 0, 0); push(4, 0, 0, 0); push(8, 0, 0, 0);
        pulse_start();
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b1;
        check_eq("restart_drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
